golden_nonce_collector: RTL and testbench

Collects golden-nonce results from NUM_CORES parallel sha256 hashing cores in the hash_clk domain. It replaces the fixed single-core 4-deep ticket/nonce shift delay with the following chain:
- per-core one-deep pending slots,
- a round-robin arbiter,
- a first-word-fall-through FIFO with a valid/ready read port.

It sits between the hashing cores and the JTAG comm block. Simultaneous tickets are no longer lost, and each result is tagged with its source core.

---
 rtl/golden_nonce_collector_pkg.sv | 22 ++
 rtl/golden_nonce_collector_if.sv | 13 +
 rtl/golden_nonce_collector_fifo.sv | 53 +++++
 rtl/golden_nonce_collector.sv | 119 +++++++++++
 tb/tb_golden_nonce_collector.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/golden_nonce_collector_pkg.sv
// Shared sizing helpers for the golden-nonce collector.
// Result entry layout: {core_id, nonce}, core_id in the MSBs.
package golden_nonce_collector_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Core id needs at least one bit even for a single core
  function automatic int core_id_w(input int ncores);
    return (ncores > 1) ? clog2(ncores) : 1;
  endfunction

  function automatic int entry_w(input int ncores, input int nonce_w);
    return core_id_w(ncores) + nonce_w;
  endfunction

endpackage

// File: rtl/golden_nonce_collector_if.sv
// Result read port: FWFT head with valid/ready handshake.
interface golden_nonce_if #(
  parameter int NONCE_WIDTH = 32,
  parameter int CORE_ID_W   = 2
);
  logic                   out_valid;
  logic                   out_ready;
  logic [NONCE_WIDTH-1:0] out_nonce;
  logic [CORE_ID_W-1:0]   out_core_id;

  modport master (output out_valid, out_nonce, out_core_id, input out_ready);
  modport slave  (input out_valid, out_nonce, out_core_id, output out_ready);
endinterface

// File: rtl/golden_nonce_collector_fifo.sv
// Synchronous first-word-fall-through FIFO; head is always rd_data.
module nonce_fifo
  import golden_nonce_collector_pkg::*;
#(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // storage write; no reset needed, contents are qualified by count
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_collector.sv
// Collects golden nonces from NUM_CORES hashing cores: one-deep pending
// slot per core, round-robin arbiter, FWFT result FIFO tagged with core id.
module golden_nonce_collector
  import golden_nonce_collector_pkg::*;
#(
  parameter  int NUM_CORES      = 4,
  parameter  int NONCE_WIDTH    = 32,
  parameter  int FIFO_DEPTH     = 8,
  parameter  int DROP_CNT_WIDTH = 16,
  localparam int CORE_ID_W      = core_id_w(NUM_CORES),
  localparam int ENTRY_W        = entry_w(NUM_CORES, NONCE_WIDTH),
  localparam int CNT_W          = clog2(FIFO_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_CORES-1:0]             core_got_ticket,
  input  logic [NUM_CORES*NONCE_WIDTH-1:0] core_golden_nonce,
  golden_nonce_if.master                   res,
  output logic [CNT_W-1:0]                 fifo_count,
  output logic [DROP_CNT_WIDTH-1:0]        drop_count,
  output logic                             overflow
);

  localparam int SUM_W = DROP_CNT_WIDTH + 5;

  logic [NUM_CORES-1:0]                  pending;
  logic [NUM_CORES-1:0][NONCE_WIDTH-1:0] slot_nonce;
  logic [NUM_CORES-1:0]                  grant_vec, drop_vec;
  logic [CORE_ID_W-1:0]                  rr_ptr, grant_id;
  logic                                  grant_vld;
  logic                                  fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]                    head;
  logic [SUM_W-1:0]                      n_drops, drop_sum;

  // a ticket on a slot that is pending and not leaving this cycle is lost
  assign drop_vec = core_got_ticket & pending & ~grant_vec;

  // round-robin search from rr_ptr; full FIFO or flush blocks any grant
  always_comb begin
    logic [CORE_ID_W:0] sum;
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    sum       = '0;
    if (!fifo_full && !flush) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        sum = {1'b0, rr_ptr} + (CORE_ID_W+1)'(k);
        if (sum >= (CORE_ID_W+1)'(NUM_CORES)) sum = sum - (CORE_ID_W+1)'(NUM_CORES);
        if (!grant_vld && pending[sum[CORE_ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_id  = sum[CORE_ID_W-1:0];
        end
      end
    end
    if (grant_vld) grant_vec[grant_id] = 1'b1;
  end

  // pending slots: load on ticket unless dropped, clear on grant
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_got_ticket[i] && !drop_vec[i]) begin
          pending[i]    <= 1'b1;
          slot_nonce[i] <= core_golden_nonce[i*NONCE_WIDTH +: NONCE_WIDTH];
        end else if (grant_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // next search starts just past the last granted core
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant_vld)
      rr_ptr <= (grant_id == CORE_ID_W'(NUM_CORES-1)) ? '0 : grant_id + CORE_ID_W'(1);
  end

  // several cores may drop in one cycle; add them all before saturating
  always_comb begin
    n_drops = '0;
    for (int i = 0; i < NUM_CORES; i++) n_drops = n_drops + SUM_W'(drop_vec[i]);
    drop_sum = SUM_W'(drop_count) + n_drops;
  end

  // saturating drop counter and sticky overflow; flush-cycle tickets never count
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (!flush && |drop_vec) begin
      drop_count <= (drop_sum > SUM_W'({DROP_CNT_WIDTH{1'b1}})) ? '1
                                                              : drop_sum[DROP_CNT_WIDTH-1:0];
      overflow   <= 1'b1;
    end
  end

  nonce_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (grant_vld),
    .push_data ({grant_id, slot_nonce[grant_id]}),
    .pop       (res.out_valid & res.out_ready),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign res.out_valid   = ~fifo_empty;
  assign res.out_core_id = head[ENTRY_W-1 -: CORE_ID_W];
  assign res.out_nonce   = head[NONCE_WIDTH-1:0];

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Directed plus random bench for golden_nonce_collector against a
// transaction-level model (slot array + result queue).
module tb_golden_nonce_collector;
  localparam int NC = 4;
  localparam int NW = 32;
  localparam int FD = 8;
  localparam int DW = 4;
  localparam int DMAX = (1 << DW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [NC-1:0]   core_got_ticket = '0;
  logic [NC*NW-1:0] core_golden_nonce = '0;
  logic [4:0]      fifo_count;
  logic [DW-1:0]   drop_count;
  logic            overflow;

  golden_nonce_if #(.NONCE_WIDTH(NW), .CORE_ID_W(2)) bus ();

  golden_nonce_collector #(.NUM_CORES(NC), .NONCE_WIDTH(NW), .FIFO_DEPTH(FD),
                           .DROP_CNT_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .core_got_ticket(core_got_ticket), .core_golden_nonce(core_golden_nonce),
    .res(bus.master), .fifo_count(fifo_count), .drop_count(drop_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] n; } ent_t;
  bit          m_pend [NC];
  logic [31:0] m_slot [NC];
  ent_t        m_q [$];
  int          m_rr, m_drop;
  bit          m_ovf;
  int          total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*NW-1:0] nv(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // reference: what one clock edge does to the slots, queue and counters
  task automatic model_step(input logic [NC-1:0] tk, input logic [NC*NW-1:0] nn,
                            input bit rdy, input bit fl, input bit rs);
    bit   op [NC];
    int   g;
    ent_t e;
    if (rs) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_q.delete(); m_rr = 0; m_drop = 0; m_ovf = 0;
    end else if (fl) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_q.delete();
    end else begin
      op = m_pend;
      g  = -1;
      if (m_q.size() < FD)
        for (int k = 0; k < NC; k++)
          if (g < 0 && op[(m_rr + k) % NC]) g = (m_rr + k) % NC;
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (g >= 0) begin
        e.id = g; e.n = m_slot[g];
        m_q.push_back(e);
        m_pend[g] = 0;
        m_rr = (g + 1) % NC;
      end
      for (int i = 0; i < NC; i++)
        if (tk[i]) begin
          if (op[i] && i != g) begin
            if (m_drop < DMAX) m_drop++;
            m_ovf = 1;
          end else begin
            m_slot[i] = nn[i*NW +: NW];
            m_pend[i] = 1;
          end
        end
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
    chk("count", 64'(fifo_count), 64'(m_q.size()));
    if (m_q.size() != 0) begin
      chk("nonce", 64'(bus.out_nonce), 64'(m_q[0].n));
      chk("core_id", 64'(bus.out_core_id), 64'(m_q[0].id));
    end
    chk("drop", 64'(drop_count), 64'(m_drop));
    chk("ovf", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic cyc(input logic [NC-1:0] tk, input logic [NC*NW-1:0] nn, input bit rdy,
                     input bit fl = 0, input bit rs = 0);
    core_got_ticket   = tk;
    core_golden_nonce = nn;
    bus.out_ready     = rdy;
    flush             = fl;
    rst               = rs;
    @(posedge clk);
    model_step(tk, nn, rdy, fl, rs);
    #1;
    check_all();
  endtask

  initial begin
    foreach (m_slot[i]) m_slot[i] = '0;
    bus.out_ready = 1'b0;

    // reset state
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0);
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_count", 64'(fifo_count), 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_ovf", 64'(overflow), 0);

    // single ticket: two-edge latency, then popped
    cyc(4'b0100, nv(0, 0, 32'h0000ABCD, 0), 1);
    chk("t1_lat", 64'(bus.out_valid), 0);
    cyc(0, 0, 1);
    chk("t1_valid", 64'(bus.out_valid), 1);
    chk("t1_nonce", 64'(bus.out_nonce), 64'h0000ABCD);
    chk("t1_id", 64'(bus.out_core_id), 2);
    cyc(0, 0, 1);
    chk("t1_empty", 64'(fifo_count), 0);

    // simultaneous tickets fill in core order
    cyc(0, 0, 0, 0, 1);
    cyc(4'hF, nv(32'h10, 32'h11, 32'h12, 32'h13), 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0);
    chk("t2_count", 64'(fifo_count), 4);
    chk("t2_drop", 64'(drop_count), 0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", 64'(bus.out_core_id), 64'(k));
      chk("t2_nonce", 64'(bus.out_nonce), 64'(32'h10 + k));
      cyc(0, 0, 1);
    end

    // round robin between cores 0 and 3
    cyc(0, 0, 0, 0, 1);
    cyc(4'b1001, nv(32'h300, 0, 0, 32'h330), 1);
    for (int k = 0; k < 6; k++) begin
      cyc(4'b1001, nv(32'h301 + k, 0, 0, 32'h331 + k), 1);
      chk("t3_alt", 64'(bus.out_core_id), (k % 2) ? 64'd3 : 64'd0);
    end
    for (int k = 0; k < 4; k++) cyc(0, 0, 1);

    // full FIFO blocks grants; second ticket on pending slot is dropped
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) cyc(4'b0001, nv(32'h100 + k, 0, 0, 0), 0);
    cyc(0, 0, 0);
    chk("t4_full", 64'(fifo_count), 8);
    cyc(4'b0010, nv(0, 32'hAA, 0, 0), 0);
    cyc(4'b0010, nv(0, 32'hBB, 0, 0), 0);
    chk("t4_drop", 64'(drop_count), 1);
    chk("t4_ovf", 64'(overflow), 1);
    cyc(0, 0, 1);
    chk("t4_pop", 64'(fifo_count), 7);
    cyc(0, 0, 0);
    chk("t4_refill", 64'(fifo_count), 8);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1);
    chk("t4_kept", 64'(bus.out_nonce), 64'hAA);
    chk("t4_kept_id", 64'(bus.out_core_id), 1);
    cyc(0, 0, 1);

    // flush with entries buffered and a slot pending
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) cyc(4'b0001, nv(32'h200 + k, 0, 0, 0), 0);
    chk("t5_pre", 64'(fifo_count), 5);
    cyc(4'b0010, nv(0, 32'h2FF, 0, 0), 1, 1);
    chk("t5_valid", 64'(bus.out_valid), 0);
    chk("t5_count", 64'(fifo_count), 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1);
    chk("t5_stay", 64'(fifo_count), 0);
    chk("t5_drop", 64'(drop_count), 0);

    // saturation, then reset restarts the search at core 0
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) cyc(4'b0111, nv($urandom, $urandom, $urandom, 0), 0);
    chk("t6_sat", 64'(drop_count), 15);
    chk("t6_ovf", 64'(overflow), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_valid", 64'(bus.out_valid), 0);
    chk("t6_count", 64'(fifo_count), 0);
    chk("t6_drop", 64'(drop_count), 0);
    chk("t6_ovf0", 64'(overflow), 0);
    cyc(4'b1010, nv(0, 32'h51, 0, 32'h53), 0);
    cyc(0, 0, 0);
    chk("t6_rr0", 64'(bus.out_core_id), 1);
    chk("t6_nonce", 64'(bus.out_nonce), 64'h51);

    // random traffic against the model
    for (int k = 0; k < 400; k++)
      cyc(NC'($urandom & $urandom), {$urandom, $urandom, $urandom, $urandom},
          bit'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
